// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage request/response bundle for the iterative multiply/divide unit.
//   master : drives start_i, op_i, a_i, b_i, flush_i; observes hi_o, lo_o, busy_o, done_o, stall_o
//   slave  : the ex_muldiv unit itself
interface ex_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_i;
    logic             op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             busy_o;
    logic             done_o;
    logic             stall_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i,
        input  hi_o, lo_o, busy_o, done_o, stall_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i,
        output hi_o, lo_o, busy_o, done_o, stall_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative unsigned multiply (shift-add) / divide (restoring), one
// iteration per clock, fixed WIDTH-cycle latency after the start edge.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : ex_muldiv_if slave -- start_i/op_i/a_i/b_i/flush_i in,
//             hi_o/lo_o/busy_o/done_o registered out, stall_o combinational out
module ex_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    ex_muldiv_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [CW-1:0]      cnt_q;
    logic               op_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               busy_d;
    logic               done_d;
    logic               accept;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_sub;
    logic               rem_ge;

    // A new operation is taken only outside BUSY and never on a flush edge
    assign accept = (state_q != S_BUSY) && bus.start_i && !bus.flush_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides start and completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start_i) state_d = S_BUSY;
            S_BUSY:  if (cnt_q == LAST) state_d = S_DONE;
            S_DONE:  state_d = bus.start_i ? S_BUSY : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush_i) begin
            state_d = S_IDLE;
        end
    end

    // Output decode; done fires only on the BUSY->DONE transition
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        busy_d = (state_d == S_BUSY);
        done_d = (state_q == S_BUSY) && (state_d == S_DONE);
    end

    // One iteration of the selected algorithm
    // MUL acc = {partial product hi, multiplier/product lo}; DIV acc = {rem, quot}
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        if (acc_q[0]) begin
            mul_sum = mul_sum + {1'b0, opnd_q};
        end
        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_ge  = (rem_sh >= {1'b0, opnd_q});
        rem_sub = rem_ge ? (rem_sh - {1'b0, opnd_q}) : rem_sh;
        if (op_q) begin
            // remainder stays below the divisor, so its top bit is always zero
            acc_nxt = {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], rem_ge};
        end else begin
            // carry out of the add becomes the new MSB after the right shift
            acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            op_q   <= 1'b0;
            opnd_q <= '0;
            acc_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            if (accept) begin
                op_q  <= bus.op_i;
                cnt_q <= '0;
                if (bus.op_i) begin
                    acc_q  <= {WIDTH'(0), bus.a_i};
                    opnd_q <= bus.b_i;
                end else begin
                    acc_q  <= {WIDTH'(0), bus.b_i};
                    opnd_q <= bus.a_i;
                end
            end else if (state_q == S_BUSY) begin
                acc_q <= acc_nxt;
                cnt_q <= cnt_q + CW'(1);
            end
            if (done_d) begin
                hi_q <= acc_nxt[2*WIDTH-1:WIDTH];
                lo_q <= acc_nxt[WIDTH-1:0];
            end
        end
    end

    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    // Holds ID/EX while computing, and on the very cycle a new request arrives
    assign bus.stall_o = (state_q == S_BUSY) | (bus.start_i & (state_q != S_BUSY));

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized and directed self-checking bench for ex_muldiv (WIDTH=32)
// against an arithmetic reference model.
module tb_ex_muldiv;
    localparam int unsigned W = 32;

    logic clk_i = 1'b0;
    logic rst_n_i;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [63:0] prev_res = 64'd0;

    ex_muldiv_if #(.WIDTH(W)) bus ();

    ex_muldiv #(.WIDTH(W)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: {hi,lo} = full product, or {remainder, quotient}
    function automatic logic [63:0] ref_result(input logic op, input logic [31:0] a, input logic [31:0] b);
        if (!op) return 64'(a) * 64'(b);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    function automatic logic [63:0] outs();
        return {bus.hi_o, bus.lo_o};
    endfunction

    // Launch one operation from IDLE, measure latency, check result and done pulse width
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b, input string tag);
        int          lat;
        logic        seen;
        logic [63:0] exp;
        exp = ref_result(op, a, b);
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.start_i = 1'b1;
        #1;
        check({tag, "_stall_req"}, 64'(bus.stall_o), 64'd1);
        step();
        bus.start_i = 1'b0;
        bus.a_i     = $urandom;
        bus.b_i     = $urandom;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            check({tag, "_busy"}, 64'(bus.busy_o), 64'd1);
            check({tag, "_hold"}, outs(), prev_res);
            step();
            lat++;
            if (bus.done_o) seen = 1'b1;
        end
        check({tag, "_latency"}, 64'(lat), 64'd32);
        check({tag, "_result"}, outs(), exp);
        check({tag, "_busy_end"}, 64'(bus.busy_o), 64'd0);
        prev_res = exp;
        step();
        check({tag, "_done_drop"}, 64'(bus.done_o), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] exp;
        int          d0;
        int          d1;
        int          nd;

        rst_n_i     = 1'b0;
        bus.start_i = 1'b0;
        bus.op_i    = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.flush_i = 1'b0;
        #12;
        check("rst_hilo", outs(), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_done", 64'(bus.done_o), 64'd0);
        check("rst_stall", 64'(bus.stall_o), 64'd0);
        #5 rst_n_i = 1'b1;

        // Directed multiply / divide cases
        run_op(1'b0, 32'h0000_FFFF, 32'h0001_0001, "mul_ffff");
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
        run_op(1'b1, 32'd100, 32'd7, "div_100_7");
        run_op(1'b1, 32'd5, 32'd0, "div_by_zero");

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) == 0)      rb = 32'd0;
            else if ($urandom_range(0, 1) == 1) rb = $urandom;
            else                                rb = 32'($urandom_range(1, 255));
            run_op(1'($urandom_range(0, 1)), ra, rb, "rand");
        end

        // start held high for 40 cycles: back-to-back issue, BUSY ignores start
        ra  = $urandom;
        rb  = $urandom;
        exp = ref_result(1'b0, ra, rb);
        bus.op_i    = 1'b0;
        bus.a_i     = ra;
        bus.b_i     = rb;
        bus.start_i = 1'b1;
        #1;
        check("hold_stall_first", 64'(bus.stall_o), 64'd1);
        d0 = -1;
        d1 = -1;
        nd = 0;
        for (int k = 0; k < 80; k++) begin
            step();
            if (bus.done_o) begin
                if (nd == 0) d0 = k;
                else if (nd == 1) d1 = k;
                nd++;
            end
            if (k == 32) check("hold_first_result", outs(), exp);
            if (k == 33) bus.a_i = ~ra;
            if (k == 39) bus.start_i = 1'b0;
            if (k == 45) check("hold_stall_busy", 64'(bus.stall_o), 64'd1);
        end
        check("hold_done0", 64'(d0), 64'd32);
        check("hold_done1", 64'(d1), 64'd65);
        check("hold_ndone", 64'(nd), 64'd2);
        check("hold_second_result", outs(), exp);
        prev_res = exp;

        // Flush at iteration 10 of a multiply
        bus.op_i    = 1'b0;
        bus.a_i     = $urandom;
        bus.b_i     = $urandom;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int i = 1; i < 10; i++) step();
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        check("flush_busy", 64'(bus.busy_o), 64'd0);
        check("flush_done", 64'(bus.done_o), 64'd0);
        check("flush_hold", outs(), prev_res);
        run_op(1'b1, 32'd1000, 32'd33, "div_after_flush");

        // Asynchronous reset in the middle of iteration 20
        bus.op_i    = 1'b0;
        bus.a_i     = $urandom;
        bus.b_i     = $urandom;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int i = 1; i <= 20; i++) step();
        #2 rst_n_i = 1'b0;
        #1;
        check("arst_hilo", outs(), 64'd0);
        check("arst_busy", 64'(bus.busy_o), 64'd0);
        check("arst_done", 64'(bus.done_o), 64'd0);
        check("arst_stall", 64'(bus.stall_o), 64'd0);
        #3 rst_n_i = 1'b1;
        prev_res = 64'd0;
        run_op(1'b0, 32'd3, 32'd4, "mul_3_4");

        // flush and start together in IDLE
        bus.op_i    = 1'b0;
        bus.a_i     = $urandom;
        bus.b_i     = $urandom;
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        check("fs_idle_busy", 64'(bus.busy_o), 64'd0);
        check("fs_idle_done", 64'(bus.done_o), 64'd0);
        step();
        check("fs_idle_busy2", 64'(bus.busy_o), 64'd0);
        check("fs_idle_hold", outs(), prev_res);

        // flush on the completing edge
        bus.op_i    = 1'b1;
        bus.a_i     = $urandom;
        bus.b_i     = 32'($urandom_range(1, 1000));
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int i = 1; i < 32; i++) step();
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        check("fs_last_done", 64'(bus.done_o), 64'd0);
        check("fs_last_busy", 64'(bus.busy_o), 64'd0);
        check("fs_last_hold", outs(), prev_res);
        step();
        check("fs_last_done2", 64'(bus.done_o), 64'd0);

        run_op(1'b1, 32'hFFFF_FFFF, 32'd1, "div_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; legal values are 8 to 64.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start_i, input, 1 bit: request a new operation, sampled on the rising edge.
REQ-005 The block SHALL have port op_i, input, 1 bit: 0 = unsigned multiply, 1 = unsigned divide; sampled with start_i.
REQ-006 The block SHALL have ports a_i and b_i, inputs, WIDTH bits each: a_i is the multiplicand or dividend, b_i is the multiplier or divisor; both are forwarded register data from the EX stage.
REQ-007 The block SHALL have port flush_i, input, 1 bit: abort any operation in flight.
REQ-008 The block SHALL have ports hi_o and lo_o, outputs, WIDTH bits each, registered: MUL gives the product {hi,lo}; DIV gives remainder in hi and quotient in lo.
REQ-009 The block SHALL have port busy_o, output, 1 bit, registered: high while state is BUSY.
REQ-010 The block SHALL have port done_o, output, 1 bit, registered: one-cycle pulse when a result is written.
REQ-011 The block SHALL have port stall_o, output, 1 bit, combinational: (state==BUSY) | (start_i & state!=BUSY); it holds the ID/EX pipeline register.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-013 In IDLE or DONE, start_i=1 at an edge SHALL capture a_i, b_i and op_i, clear the iteration counter and enter BUSY.
REQ-014 In DONE, start_i=0 SHALL return the FSM to IDLE.
REQ-015 In BUSY, the block SHALL perform one iteration per edge; the iteration counter is clog2(WIDTH) bits wide.
REQ-016 MUL SHALL use shift-add: if the multiplier LSB is 1, add the multiplicand to the upper half of a 2*WIDTH accumulator with carry kept, then shift right by 1.
REQ-017 DIV SHALL use restoring division: shift {rem,quot} left by 1; if rem >= divisor, subtract the divisor and set the quotient LSB.
REQ-018 The WIDTH-th iteration SHALL write hi_o/lo_o at that same edge, set done_o=1, clear busy_o and enter DONE.
REQ-019 Latency SHALL be fixed: start accepted at edge E0, result and done_o visible after edge E(WIDTH), so after E32 for the default; the latency is independent of operand values.
REQ-020 start_i SHALL be ignored while in BUSY.
REQ-021 done_o SHALL be high for exactly one cycle per completed operation.
REQ-022 Back-to-back operation SHALL work: start_i in DONE begins the next operation with no idle cycle, and done_o still drops after one cycle.
REQ-023 Divide by zero SHALL give lo_o = all ones and hi_o = the dividend, with the same latency as any other divide; this falls out of restoring division with no special case.
REQ-024 flush_i=1 at an edge SHALL force IDLE and clear busy_o and done_o; hi_o/lo_o SHALL keep their previous values; flush_i has priority over start_i and over completion.
REQ-025 hi_o/lo_o SHALL change only on completion or on reset.
REQ-026 The block SHALL be overflow-free: the product is exactly 2*WIDTH bits, quotient and remainder WIDTH bits each, and no intermediate truncation is allowed.

Reset
REQ-027 rst_n_i=0 SHALL immediately and asynchronously force IDLE with hi_o=0, lo_o=0, busy_o=0, done_o=0 and the counter = 0.
REQ-028 Reset SHALL take effect in every state, including mid-BUSY; the partial result is discarded.
REQ-029 After reset deasserts, the first rising edge SHALL accept start_i.

Verification
REQ-030 The bench SHALL cover MUL: a=0x0000FFFF, b=0x00010001, start for one cycle -> done_o after 32 edges, hi=0x00000000, lo=0xFFFFFFFF; a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 The bench SHALL cover DIV: a=100, b=7 -> lo=14, hi=2; a=5, b=0 -> lo=0xFFFFFFFF, hi=5, same 32-edge latency.
REQ-032 The bench SHALL cover stall and ignore: start held high for 40 cycles -> stall_o high from the first cycle; the second operation begins exactly at the DONE cycle; the start seen during BUSY is ignored; done_o pulses are exactly 33 cycles apart.
REQ-033 The bench SHALL cover flush: flush_i at iteration 10 of a MUL -> IDLE on the next cycle, busy_o=0, no done_o, hi/lo equal to the prior result; a new DIV started immediately then completes correctly.
REQ-034 The bench SHALL cover reset mid-operation: rst_n_i low at iteration 20, asynchronously between edges -> all outputs 0 at once; after release, MUL 3*4 -> lo=12.
REQ-035 The bench SHALL cover simultaneous events: flush_i and start_i together in IDLE -> the FSM stays IDLE; flush_i on the completing edge -> no done_o and hi/lo unchanged.
